// File: rtl/bnn_req_arbiter.sv
// Round-robin front end that shares one binarized-NN classifier core between
// NUM_REQ AXI-Stream image sources. Exactly one image is in flight at a time;
// the grant index travels on the core TID and the class result is returned to
// the granted requester only. Per-requester completion counters and a sticky
// TID-mismatch flag are kept for debug.
module bnn_req_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int TID_WIDTH  = 4,
  parameter int NUM_REQ    = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_tdata,
  input  logic [NUM_REQ-1:0]              req_tvalid,
  output logic [NUM_REQ-1:0]              req_tready,
  output logic [7:0]                      res_tdata,
  output logic [NUM_REQ-1:0]              res_tvalid,
  input  logic [NUM_REQ-1:0]              res_tready,
  output logic [DATA_WIDTH-1:0]           accel_s_tdata,
  output logic                            accel_s_tvalid,
  input  logic                            accel_s_tready,
  output logic [TID_WIDTH-1:0]            accel_s_tid,
  input  logic [7:0]                      accel_m_tdata,
  input  logic                            accel_m_tvalid,
  output logic                            accel_m_tready,
  input  logic [TID_WIDTH-1:0]            accel_m_tid,
  output logic [NUM_REQ*CNT_WIDTH-1:0]    done_count,
  output logic                            busy,
  output logic                            err_tid
);

  localparam int          GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned NR = NUM_REQ;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [GW-1:0]        grant, grant_nxt;
  logic [GW-1:0]        last_grant;
  logic [GW-1:0]        pick;
  logic                 res_done;
  logic [CNT_WIDTH-1:0] cnt [NUM_REQ];

  // Round-robin pick: first valid requester after last_grant, wrapping.
  always_comb begin
    int unsigned idx;
    logic        found;
    pick  = grant;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 1; i <= NR; i++) begin
      idx = (32'(last_grant) + i) % NR;
      if (!found && req_tvalid[idx[GW-1:0]]) begin
        found = 1'b1;
        pick  = idx[GW-1:0];
      end
    end
  end

  // Sequencer next-state and handshake routing for the granted requester.
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    req_tready     = '0;
    res_tvalid     = '0;
    accel_s_tvalid = 1'b0;
    accel_m_tready = 1'b0;
    res_done       = 1'b0;
    accel_s_tdata  = req_tdata[grant*DATA_WIDTH +: DATA_WIDTH];
    accel_s_tid    = TID_WIDTH'(grant);
    case (state)
      ST_IDLE: begin
        if (|req_tvalid) begin
          grant_nxt = pick;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        accel_s_tvalid    = req_tvalid[grant];
        req_tready[grant] = accel_s_tready;
        if (req_tvalid[grant] && accel_s_tready) begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        res_tvalid[grant] = accel_m_tvalid;
        accel_m_tready    = res_tready[grant];
        if (accel_m_tvalid && res_tready[grant]) begin
          res_done  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign res_tdata = accel_m_tdata;
  assign busy      = (state != ST_IDLE);

  // State, grant bookkeeping and sticky TID check.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      grant      <= '0;
      last_grant <= GW'(NUM_REQ - 1);
      err_tid    <= 1'b0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      if (res_done) begin
        last_grant <= grant;
        if (accel_m_tid != TID_WIDTH'(grant)) begin
          err_tid <= 1'b1;
        end
      end
    end
  end

  // Per-requester completion counters, wrapping naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NR; i++) begin
        cnt[i] <= '0;
      end
    end else if (res_done) begin
      cnt[grant] <= cnt[grant] + CNT_WIDTH'(1);
    end
  end

  // Flatten the counter array onto the output bus.
  always_comb begin
    done_count = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      done_count[i*CNT_WIDTH +: CNT_WIDTH] = cnt[i];
    end
  end

endmodule
